// File: rtl/tile_link_arb_if.sv
// Link arbiter bundle: requester handshakes, outbound link beat, credit return and status.
// Latency: none; this is wiring only.
// Backpressure: req_ready is driven by the arbiter; credit_ret comes from the downstream tile.
interface tile_link_arb_if #(
    parameter int NREQ = 4,
    parameter int W    = 123
);
    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_last;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              link_snd;
    logic [W-1:0]      link_data;
    logic              credit_ret;
    logic [OW-1:0]     owner;
    logic              locked;
    logic              cred_err;

    // Requesters and the downstream tile drive the master side.
    modport master (
        output req_valid, req_last, req_data, credit_ret,
        input  req_ready, link_snd, link_data, owner, locked, cred_err
    );

    // The arbiter is the slave side.
    modport slave (
        input  req_valid, req_last, req_data, credit_ret,
        output req_ready, link_snd, link_data, owner, locked, cred_err
    );
endinterface

// File: rtl/tile_link_arb.sv
// Shares one mesh outbound link among NREQ requesters (port 0 = through-traffic), packets kept atomic.
// Latency: accepted beat appears on link_data/link_snd one cycle after the req_valid&req_ready cycle.
// Backpressure: req_ready is one-hot or zero and drops to zero whenever downstream credits are exhausted.
module tile_link_arb #(
    parameter int NREQ       = 4,
    parameter int W          = 123,
    parameter int CREDITS    = 8,
    parameter int STARVE_MAX = 6
) (
    input  logic              clk,
    input  logic              rst,
    tile_link_arb_if.slave    bus
);
    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(CREDITS + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic {S_IDLE, S_LOCK} state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cred, w_cred_nxt;
    logic [OW-1:0]   r_rr_ptr, w_rr_nxt;
    logic [OW-1:0]   r_owner, w_owner_nxt;
    logic [SW-1:0]   r_starve, w_starve_nxt;
    logic            r_link_snd;
    logic [W-1:0]    r_link_data;
    logic            r_cred_err;

    logic [NREQ-1:0] w_ready;
    logic            w_found;
    logic [OW-1:0]   w_winner;
    logic [OW-1:0]   w_idx;
    logic [OW-1:0]   w_sel;
    logic            w_has_cred;
    logic            w_xfer;

    // Wrap-around increment so non-power-of-two NREQ also rotates correctly.
    function automatic logic [OW-1:0] f_inc(input logic [OW-1:0] p);
        if (p == OW'(NREQ - 1)) f_inc = '0;
        else                    f_inc = p + OW'(1);
    endfunction

    assign w_has_cred = (r_cred != '0);
    assign w_xfer     = |(w_ready & bus.req_valid);

    // Round-robin scan from rr_ptr, then the starvation override for through-traffic.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = OW'((int'(r_rr_ptr) + k) % NREQ);
            if (!w_found && bus.req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
        if ((r_starve == SW'(STARVE_MAX)) && bus.req_valid[0]) begin
            w_found  = 1'b1;
            w_winner = '0;
        end
    end

    // FSM next state, grants, pointer/owner/starvation updates.
    always_comb begin
        w_state_nxt  = r_state;
        w_rr_nxt     = r_rr_ptr;
        w_owner_nxt  = r_owner;
        w_starve_nxt = r_starve;
        w_ready      = '0;
        w_sel        = r_owner;
        case (r_state)
            S_IDLE: begin
                w_sel = w_winner;
                if (w_has_cred) begin
                    // Only real arbitration cycles age or clear the starvation count.
                    if (bus.req_valid[0] && !(w_found && (w_winner == '0)))
                        w_starve_nxt = (r_starve == SW'(STARVE_MAX)) ? r_starve : r_starve + SW'(1);
                    else
                        w_starve_nxt = '0;
                    if (w_found) begin
                        w_ready[w_winner] = 1'b1;
                        w_owner_nxt       = w_winner;
                        if (bus.req_last[w_winner]) w_rr_nxt    = f_inc(w_winner);
                        else                        w_state_nxt = S_LOCK;
                    end
                end
            end
            S_LOCK: begin
                // Owner keeps the link; ready does not wait on its valid so a stalled
                // owner simply leaves the link idle.
                w_ready[r_owner] = w_has_cred;
                if (w_has_cred && bus.req_valid[r_owner] && bus.req_last[r_owner]) begin
                    w_state_nxt = S_IDLE;
                    w_rr_nxt    = f_inc(r_owner);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Credit counter: a transfer and a return in the same cycle cancel out.
    always_comb begin
        w_cred_nxt = r_cred;
        case ({w_xfer, bus.credit_ret})
            2'b10:   w_cred_nxt = r_cred - CW'(1);
            2'b01:   w_cred_nxt = (r_cred == CW'(CREDITS)) ? r_cred : r_cred + CW'(1);
            default: w_cred_nxt = r_cred;
        endcase
    end

    // State registers and the registered link beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cred      <= CW'(CREDITS);
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_starve    <= '0;
            r_link_snd  <= 1'b0;
            r_link_data <= '0;
            r_cred_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cred     <= w_cred_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_owner    <= w_owner_nxt;
            r_starve   <= w_starve_nxt;
            r_link_snd <= w_xfer;
            if (w_xfer)
                r_link_data <= bus.req_data[int'(w_sel)*W +: W];
            if (bus.credit_ret && (r_cred == CW'(CREDITS)))
                r_cred_err <= 1'b1;
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.link_snd  = r_link_snd;
    assign bus.link_data = r_link_data;
    assign bus.owner     = r_owner;
    assign bus.locked    = (r_state == S_LOCK);
    assign bus.cred_err  = r_cred_err;
endmodule

// File: tb/tb_tile_link_arb.sv
// Directed bench for tile_link_arb: reset, round robin, credits, atomicity, starvation.
// Latency: checks req_ready combinationally and link outputs one cycle after the transfer.
// Backpressure: credit exhaustion and return are driven explicitly through credit_ret.
module tb_tile_link_arb;
    localparam int NREQ = 4;
    localparam int W    = 123;

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;
    int   seq;

    tile_link_arb_if #(.NREQ(NREQ), .W(W)) u_if ();
    tile_link_arb_if #(.NREQ(NREQ), .W(W)) u_if_s ();

    // Default-parameter arbiter.
    tile_link_arb #(.NREQ(NREQ), .W(W), .CREDITS(8), .STARVE_MAX(6)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    // With four ports, round robin alone caps port-0 losses at three, so this
    // instance uses a short starvation limit to reach the override.
    tile_link_arb #(.NREQ(NREQ), .W(W), .CREDITS(8), .STARVE_MAX(2)) u_dut_s (
        .clk (clk),
        .rst (rst),
        .bus (u_if_s)
    );

    assign u_if_s.req_valid  = u_if.req_valid;
    assign u_if_s.req_last   = u_if.req_last;
    assign u_if_s.req_data   = u_if.req_data;
    assign u_if_s.credit_ret = u_if.credit_ret;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] beat(input int p, input int s);
        logic [W-1:0] b;
        b           = '0;
        b[W-1 -: 8] = 8'h80 | 8'(p);
        b[23:0]     = {8'(p), 16'(s)};
        return b;
    endfunction

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One cycle: drive inputs, check ready, clock, check the registered beat.
    task automatic step(input string tag, input logic [3:0] v, input logic [3:0] l,
                        input logic cr, input logic [3:0] exp_rdy, input logic exp_snd,
                        input int exp_own, input bit cs = 1'b0,
                        input logic [3:0] exp_rdy_s = 4'b0000);
        u_if.req_valid  = v;
        u_if.req_last   = l;
        u_if.credit_ret = cr;
        for (int p = 0; p < NREQ; p++)
            u_if.req_data[p*W +: W] = beat(p, seq);
        #1;
        check({tag, ".rdy"}, 128'(u_if.req_ready), 128'(exp_rdy));
        if (cs) check({tag, ".rdy_s"}, 128'(u_if_s.req_ready), 128'(exp_rdy_s));
        @(posedge clk);
        #1;
        check({tag, ".snd"}, 128'(u_if.link_snd), 128'(exp_snd));
        if (exp_snd) begin
            check({tag, ".own"}, 128'(u_if.owner), 128'(exp_own));
            check({tag, ".dat"}, 128'(u_if.link_data), 128'(beat(exp_own, seq)));
        end
        seq++;
    endtask

    task automatic do_reset();
        u_if.req_valid  = '0;
        u_if.req_last   = '0;
        u_if.credit_ret = 1'b0;
        rst = 1'b0;
        #1;
        rst = 1'b1;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        seq     = 0;
        rst     = 1'b0;
        u_if.req_valid  = '0;
        u_if.req_last   = '0;
        u_if.req_data   = '0;
        u_if.credit_ret = 1'b0;
        #1;
        check("rst.snd",    128'(u_if.link_snd),  128'(0));
        check("rst.dat",    128'(u_if.link_data), 128'(0));
        check("rst.own",    128'(u_if.owner),     128'(0));
        check("rst.lock",   128'(u_if.locked),    128'(0));
        check("rst.err",    128'(u_if.cred_err),  128'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Reset in the middle of a multi-beat packet.
        step("mid", 4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b1, 2);
        check("mid.lock", 128'(u_if.locked), 128'(1));
        rst = 1'b0;
        #1;
        check("mid.rst_snd",  128'(u_if.link_snd), 128'(0));
        check("mid.rst_lock", 128'(u_if.locked),   128'(0));
        check("mid.rst_own",  128'(u_if.owner),    128'(0));
        check("mid.rst_dat",  128'(u_if.link_data), 128'(0));
        rst = 1'b1;
        step("post_rst", 4'b1111, 4'b1111, 1'b0, 4'b0001, 1'b1, 0);

        // Round robin with continuous credit return.
        do_reset();
        step("rr0", 4'b1111, 4'b1111, 1'b0, 4'b0001, 1'b1, 0);
        for (int i = 1; i < 8; i++)
            step($sformatf("rr%0d", i), 4'b1111, 4'b1111, 1'b1,
                 4'(1 << (i % 4)), 1'b1, i % 4);
        check("rr.err", 128'(u_if.cred_err), 128'(0));

        // Credit exhaustion and single return.
        do_reset();
        for (int i = 0; i < 8; i++)
            step($sformatf("ex%0d", i), 4'b0010, 4'b0010, 1'b0, 4'b0010, 1'b1, 1);
        step("ex_empty", 4'b0010, 4'b0010, 1'b0, 4'b0000, 1'b0, 0);
        step("ex_ret",   4'b0010, 4'b0010, 1'b1, 4'b0000, 1'b0, 0);
        step("ex_one",   4'b0010, 4'b0010, 1'b0, 4'b0010, 1'b1, 1);
        step("ex_again", 4'b0010, 4'b0010, 1'b0, 4'b0000, 1'b0, 0);

        // Atomicity: port 2 four-beat packet against competing requesters.
        do_reset();
        step("at_p0", 4'b0001, 4'b1111, 1'b0, 4'b0001, 1'b1, 0);
        step("at_p1", 4'b0010, 4'b1111, 1'b0, 4'b0010, 1'b1, 1);
        step("at_b1", 4'b1111, 4'b1011, 1'b0, 4'b0100, 1'b1, 2);
        check("at_b1.lock", 128'(u_if.locked), 128'(1));
        step("at_b2", 4'b1111, 4'b1011, 1'b0, 4'b0100, 1'b1, 2);
        step("at_gap", 4'b1011, 4'b1011, 1'b0, 4'b0100, 1'b0, 0);
        check("at_gap.lock", 128'(u_if.locked), 128'(1));
        step("at_b3", 4'b1111, 4'b1011, 1'b0, 4'b0100, 1'b1, 2);
        step("at_b4", 4'b1111, 4'b1111, 1'b0, 4'b0100, 1'b1, 2);
        check("at_b4.lock", 128'(u_if.locked), 128'(0));
        step("at_p3", 4'b1111, 4'b1111, 1'b0, 4'b1000, 1'b1, 3);

        // Starvation override (short-limit instance) against plain round robin.
        do_reset();
        step("st0", 4'b0001, 4'b1111, 1'b0, 4'b0001, 1'b1, 0, 1'b1, 4'b0001);
        step("st1", 4'b1111, 4'b1111, 1'b0, 4'b0010, 1'b1, 1, 1'b1, 4'b0010);
        step("st2", 4'b1111, 4'b1111, 1'b0, 4'b0100, 1'b1, 2, 1'b1, 4'b0100);
        step("st3", 4'b1111, 4'b1111, 1'b0, 4'b1000, 1'b1, 3, 1'b1, 4'b0001);
        check("st3.own_s", 128'(u_if_s.owner), 128'(0));
        step("st4", 4'b1111, 4'b1111, 1'b0, 4'b0001, 1'b1, 0, 1'b1, 4'b0010);

        // Credit edges: simultaneous transfer+return, then overflow return.
        do_reset();
        step("ce_first", 4'b0010, 4'b0010, 1'b0, 4'b0010, 1'b1, 1);
        for (int i = 0; i < 4; i++)
            step($sformatf("ce_both%0d", i), 4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b1, 1);
        for (int i = 0; i < 7; i++)
            step($sformatf("ce_drain%0d", i), 4'b0010, 4'b0010, 1'b0, 4'b0010, 1'b1, 1);
        step("ce_empty", 4'b0010, 4'b0010, 1'b0, 4'b0000, 1'b0, 0);
        check("ce.err0", 128'(u_if.cred_err), 128'(0));
        for (int i = 0; i < 8; i++)
            step($sformatf("ce_ret%0d", i), 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 0);
        check("ce.err1", 128'(u_if.cred_err), 128'(0));
        step("ce_over", 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 0);
        check("ce.err2", 128'(u_if.cred_err), 128'(1));
        for (int i = 0; i < 8; i++)
            step($sformatf("ce_full%0d", i), 4'b0010, 4'b0010, 1'b0, 4'b0010, 1'b1, 1);
        step("ce_full_end", 4'b0010, 4'b0010, 1'b0, 4'b0000, 1'b0, 0);
        check("ce.err3", 128'(u_if.cred_err), 128'(1));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
